// File: rtl/mfcc_frame_sequencer.sv
// mfcc_frame_sequencer
// Frame scheduler for the MFCC front end. It waits for a frame from the window buffer and
// starts the Hamming window on it. It then hands the windowed frame to the FFT and slides
// the window buffer by one hop. It counts frames, reports completion, and abandons a run
// that stalls in a downstream handshake.
module mfcc_frame_sequencer #(
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [FRAME_CNT_WIDTH-1:0] num_frames_i,
  input  logic                       win_frame_rdy_i,
  input  logic                       win_idle_i,
  output logic                       win_move_o,
  output logic                       ham_start_o,
  input  logic                       ham_done_i,
  input  logic                       fft_ready_i,
  output logic                       fft_start_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_idx_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       timeout_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_HAM_RUN,
    S_WAIT_FFT,
    S_MOVE,
    S_FINISH
  } state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1; a zero setting disables the watchdog.
  localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit            TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

  state_t                     state;
  logic                       pending;
  logic [FRAME_CNT_WIDTH-1:0] n_tgt;
  logic [TW-1:0]              tmo_cnt;
  logic [FRAME_CNT_WIDTH-1:0] idx_next;
  logic                       tmo_hit;

  // Next frame index and watchdog expiry, shared by the state machine below.
  assign idx_next = frame_idx_o + FRAME_CNT_WIDTH'(1);
  assign tmo_hit  = TO_EN && (tmo_cnt == TO_LAST);

  // Sequencer state machine with registered pulse, status and counter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including the frame target, is cleared here so a reset mid-run
      // cuts in-flight pulses and leaves no stale target for the next start.
      state         <= S_IDLE;
      pending       <= 1'b0;
      n_tgt         <= '0;
      tmo_cnt       <= '0;
      frame_idx_o   <= '0;
      win_move_o    <= 1'b0;
      ham_start_o   <= 1'b0;
      fft_start_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the same cycle overrides,
      // which keeps every pulse to a single cycle and restarts the watchdog on state entry.
      win_move_o  <= 1'b0;
      ham_start_o <= 1'b0;
      fft_start_o <= 1'b0;
      done_o      <= 1'b0;
      tmo_cnt     <= '0;

      // An early frame-ready pulse is remembered once; extra pulses fold into the same flag.
      if (win_frame_rdy_i && state != S_IDLE && state != S_WAIT_FRAME)
        pending <= 1'b1;

      if (abort_i) begin
        state   <= S_IDLE;
        busy_o  <= 1'b0;
        pending <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            pending <= 1'b0;
            if (start_i) begin
              n_tgt         <= num_frames_i;
              frame_idx_o   <= '0;
              timeout_err_o <= 1'b0;
              busy_o        <= 1'b1;
              state         <= S_WAIT_FRAME;
            end
          end
          S_WAIT_FRAME: begin
            if (win_frame_rdy_i || pending) begin
              pending     <= 1'b0;
              ham_start_o <= 1'b1;
              state       <= S_HAM_RUN;
            end
          end
          S_HAM_RUN: begin
            if (ham_done_i) begin
              if (fft_ready_i) begin
                fft_start_o <= 1'b1;
                state       <= S_MOVE;
              end else begin
                state <= S_WAIT_FFT;
              end
            end else if (tmo_hit) begin
              timeout_err_o <= 1'b1;
              busy_o        <= 1'b0;
              pending       <= 1'b0;
              state         <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          S_WAIT_FFT: begin
            if (fft_ready_i) begin
              fft_start_o <= 1'b1;
              state       <= S_MOVE;
            end else if (tmo_hit) begin
              timeout_err_o <= 1'b1;
              busy_o        <= 1'b0;
              pending       <= 1'b0;
              state         <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          S_MOVE: begin
            if (win_idle_i) begin
              win_move_o  <= 1'b1;
              frame_idx_o <= idx_next;
              state       <= (n_tgt != '0 && idx_next == n_tgt) ? S_FINISH : S_WAIT_FRAME;
            end else if (tmo_hit) begin
              timeout_err_o <= 1'b1;
              busy_o        <= 1'b0;
              pending       <= 1'b0;
              state         <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          S_FINISH: begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
          default: begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Testbench for mfcc_frame_sequencer: directed scenarios plus randomized runs. Expected
// behaviour comes from frame-level rules: per-stage handshake latencies, a one-deep early
// frame token, and frame/pulse totals per run.
module tb_mfcc_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] num_frames = '0;
  logic        win_frame_rdy = 1'b0, win_idle = 1'b0, ham_done = 1'b0, fft_ready = 1'b0;
  logic        win_move, ham_start, fft_start, busy, done, timeout_err;
  logic [15:0] frame_idx;

  // Second instance with a short watchdog, driven only by the timeout scenario.
  logic        t_start = 1'b0, t_abort = 1'b0, t_rdy = 1'b0;
  logic        t_win_move, t_ham_start, t_fft_start, t_busy, t_done, t_terr;
  logic [15:0] t_frame_idx;

  int tests = 0, fails = 0;
  int n_ham = 0, n_fft = 0, n_move = 0, n_done = 0, viol = 0;
  logic p_ham = 1'b0, p_fft = 1'b0, p_move = 1'b0, p_done = 1'b0;

  // Reference state: frames completed this run and the one-deep early frame token.
  int exp_idx = 0;
  bit tok = 1'b0;

  mfcc_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .num_frames_i(num_frames),
    .win_frame_rdy_i(win_frame_rdy), .win_idle_i(win_idle), .win_move_o(win_move),
    .ham_start_o(ham_start), .ham_done_i(ham_done), .fft_ready_i(fft_ready),
    .fft_start_o(fft_start), .frame_idx_o(frame_idx), .busy_o(busy), .done_o(done),
    .timeout_err_o(timeout_err)
  );

  mfcc_frame_sequencer #(.FRAME_CNT_WIDTH(16), .TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .rst_n(rst_n), .start_i(t_start), .abort_i(t_abort), .num_frames_i(16'd1),
    .win_frame_rdy_i(t_rdy), .win_idle_i(1'b0), .win_move_o(t_win_move),
    .ham_start_o(t_ham_start), .ham_done_i(1'b0), .fft_ready_i(1'b0),
    .fft_start_o(t_fft_start), .frame_idx_o(t_frame_idx), .busy_o(t_busy), .done_o(t_done),
    .timeout_err_o(t_terr)
  );

  always #5 clk = ~clk;

  // Pulse totals and back-to-back pulse detection, sampled mid-cycle.
  always @(negedge clk) begin
    if (ham_start) n_ham <= n_ham + 1;
    if (fft_start) n_fft <= n_fft + 1;
    if (win_move)  n_move <= n_move + 1;
    if (done)      n_done <= n_done + 1;
    if ((ham_start && p_ham) || (fft_start && p_fft) || (win_move && p_move) || (done && p_done))
      viol <= viol + 1;
    p_ham  <= ham_start;
    p_fft  <= fft_start;
    p_move <= win_move;
    p_done <= done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] n);
    num_frames = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_idx", 32'(frame_idx), 0);
    check("start_terr", 32'(timeout_err), 0);
    exp_idx = 0;
    tok = 1'b0;
  endtask

  // One frame through the pipeline. Entry and exit are in a cycle where the sequencer
  // waits for a frame. early = number of frame-ready pulses injected during the Hamming run.
  task automatic do_frame(input int rdy_dly, input int ham_dly, input int fft_dly,
                          input int idle_dly, input int early, input bit last);
    if (tok) begin
      tick();
      check("ham_start_pending", 32'(ham_start), 1);
      tok = 1'b0;
    end else begin
      for (int i = 0; i < rdy_dly; i++) begin
        check("ham_start_early", 32'(ham_start), 0);
        tick();
      end
      win_frame_rdy = 1'b1;
      tick();
      win_frame_rdy = 1'b0;
      check("ham_start_lat", 32'(ham_start), 1);
    end
    for (int i = 0; i < ham_dly; i++) begin
      win_frame_rdy = (early >= 1 && i == 1) || (early >= 2 && i == 3);
      tick();
    end
    win_frame_rdy = 1'b0;
    tok = (early > 0);
    check("fft_start_before_done", 32'(fft_start), 0);
    ham_done  = 1'b1;
    fft_ready = (fft_dly == 0);
    tick();
    ham_done = 1'b0;
    if (fft_dly != 0) begin
      for (int i = 0; i < fft_dly; i++) begin
        check("fft_start_held", 32'(fft_start), 0);
        tick();
      end
      fft_ready = 1'b1;
      tick();
    end
    check("fft_start_lat", 32'(fft_start), 1);
    fft_ready = 1'b0;
    win_idle  = 1'b0;
    for (int i = 0; i < idle_dly; i++) begin
      tick();
      check("win_move_held", 32'(win_move), 0);
    end
    win_idle = 1'b1;
    tick();
    check("win_move_lat", 32'(win_move), 1);
    exp_idx++;
    check("frame_idx", 32'(frame_idx), 32'(exp_idx));
    if (last) begin
      tick();
      check("done_pulse", 32'(done), 1);
      check("done_busy", 32'(busy), 0);
      check("done_idx", 32'(frame_idx), 32'(exp_idx));
      tok = 1'b0;
    end else begin
      check("mid_busy", 32'(busy), 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {win_move, ham_start, fft_start, frame_idx, busy, done, timeout_err,
                t_win_move, t_ham_start, t_fft_start, t_frame_idx, t_busy, t_done, t_terr}, 0);
  endtask

  initial begin
    int h0, f0, m0, d0, n;

    // Reset state
    #12;
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset_outputs");

    // T1: three frames, slow Hamming, downstream always ready
    h0 = n_ham; f0 = n_fft; m0 = n_move; d0 = n_done;
    start_run(16'd3);
    do_frame(10, 50, 0, 0, 0, 1'b0);
    do_frame(10, 50, 0, 0, 0, 1'b0);
    do_frame(10, 50, 0, 0, 0, 1'b1);
    tick();
    check("t1_ham_cnt", 32'(n_ham - h0), 3);
    check("t1_fft_cnt", 32'(n_fft - f0), 3);
    check("t1_move_cnt", 32'(n_move - m0), 3);
    check("t1_done_cnt", 32'(n_done - d0), 1);
    check("t1_idx_final", 32'(frame_idx), 3);

    // T2: FFT back-pressure for 20 cycles, plus window-buffer back-pressure
    start_run(16'd2);
    do_frame(3, 8, 20, 0, 0, 1'b0);
    do_frame(0, 6, 20, 3, 0, 1'b1);

    // T3: early frame-ready during the Hamming run, second early pulse dropped
    h0 = n_ham;
    start_run(16'd3);
    do_frame(2, 10, 0, 0, 2, 1'b0);
    do_frame(0, 10, 0, 0, 0, 1'b0);
    do_frame(6, 10, 0, 0, 0, 1'b1);
    tick();
    check("t3_ham_cnt", 32'(n_ham - h0), 3);

    // T4: abort in the same cycle as ham_done
    start_run(16'd2);
    do_frame(1, 5, 0, 0, 0, 1'b0);
    f0 = n_fft; d0 = n_done;
    win_frame_rdy = 1'b1;
    tick();
    win_frame_rdy = 1'b0;
    check("t4_ham_start", 32'(ham_start), 1);
    tick();
    ham_done = 1'b1; fft_ready = 1'b1; abort = 1'b1;
    tick();
    ham_done = 1'b0; fft_ready = 1'b0; abort = 1'b0;
    check("t4_busy", 32'(busy), 0);
    check("t4_fft_start", 32'(fft_start), 0);
    check("t4_idx_hold", 32'(frame_idx), 1);
    repeat (4) tick();
    check("t4_fft_cnt", 32'(n_fft - f0), 0);
    check("t4_done_cnt", 32'(n_done - d0), 0);

    // T5: watchdog on the 16-cycle instance, Hamming never finishes
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    t_rdy = 1'b1;
    tick();
    t_rdy = 1'b0;
    check("t5_ham_start", 32'(t_ham_start), 1);
    repeat (15) tick();
    check("t5_terr_before", 32'(t_terr), 0);
    check("t5_busy_before", 32'(t_busy), 1);
    tick();
    check("t5_terr_set", 32'(t_terr), 1);
    check("t5_busy_after", 32'(t_busy), 0);
    repeat (3) tick();
    check("t5_terr_sticky", 32'(t_terr), 1);
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    check("t5_terr_cleared", 32'(t_terr), 0);
    check("t5_busy_restart", 32'(t_busy), 1);
    t_abort = 1'b1;
    tick();
    t_abort = 1'b0;
    check("t5_abort_idle", 32'(t_busy), 0);

    // Randomized runs against the frame-level model
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      h0 = n_ham; f0 = n_fft; m0 = n_move; d0 = n_done;
      start_run(16'(n));
      for (int f = 0; f < n; f++)
        do_frame($urandom_range(0, 12), $urandom_range(5, 30),
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 8),
                 $urandom_range(0, 4), (f < n - 1) ? $urandom_range(0, 2) : 0, f == n - 1);
      tick();
      check("rnd_ham_cnt", 32'(n_ham - h0), 32'(n));
      check("rnd_fft_cnt", 32'(n_fft - f0), 32'(n));
      check("rnd_move_cnt", 32'(n_move - m0), 32'(n));
      check("rnd_done_cnt", 32'(n_done - d0), 1);
      check("rnd_terr", 32'(timeout_err), 0);
    end

    // T6: continuous mode, five frames, abort; then reset in the middle of MOVE
    d0 = n_done;
    start_run(16'd0);
    for (int f = 0; f < 5; f++)
      do_frame($urandom_range(0, 5), $urandom_range(5, 12), 0, $urandom_range(0, 2), 0, 1'b0);
    check("t6_idx5", 32'(frame_idx), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_busy", 32'(busy), 0);
    check("t6_abort_idx", 32'(frame_idx), 5);
    repeat (3) tick();
    check("t6_done_cnt", 32'(n_done - d0), 0);

    start_run(16'd0);
    win_idle = 1'b0;
    win_frame_rdy = 1'b1;
    tick();
    win_frame_rdy = 1'b0;
    repeat (3) tick();
    ham_done = 1'b1; fft_ready = 1'b1;
    tick();
    ham_done = 1'b0; fft_ready = 1'b0;
    check("t6_fft_start", 32'(fft_start), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_reset_cut");
    repeat (3) begin
      tick();
      check_all_zero("t6_in_reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    win_idle = 1'b1;
    repeat (2) tick();
    check_all_zero("t6_after_reset");
    check("t6_done_total", 32'(n_done - d0), 0);

    check("no_back_to_back_pulses", 32'(viol), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
